mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle successor to the single-cycle MIPS control decoder: a Moore-style FSM that steps each instruction through fetch/decode/execute/memory/writeback and drives the shared-ALU, single-memory multi-cycle datapath. It adds a memory ready handshake with a bounded wait timeout, illegal-opcode reporting and a parametrised ALU-op width. It sits between the instruction register opcode field and every datapath mux/enable in the multi-cycle core.

## Interface
- `ALUOP_W`, 3: width of `alu_op`; must be ≥3; codes zero-extended.
- `WAIT_MAX`, 15: max consecutive `mem_ready`=0 cycles tolerated in a memory state; 0 disables the timeout.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; state → FETCH, counters cleared.
- `op_code`  in  6  opcode from instruction register, valid from DECODE onward.
- `zero`  in  1  ALU zero flag, sampled in BRANCH.
- `mem_ready`  in  1  memory completes current read/write this cycle.
- `pc_write`  out  1  PC load enable.
- `ir_write`  out  1  instruction register load.
- `i_or_d`  out  1  memory address select: 0 PC, 1 ALUOut.
- `mem_read`, `mem_write`  out  1  memory strobes, held until `mem_ready`.
- `mem_to_reg`  out  1  writeback data: 0 ALUOut, 1 MDR.
- `reg_dst`  out  1  write reg: 0 rt, 1 rd.
- `reg_write`  out  1  register file write enable.
- `jal_link`  out  1  force write reg 31, data PC.
- `alu_src_a`  out  1  0 PC, 1 rs.
- `alu_src_b`  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `alu_op`  out  ALUOP_W  000 add, 001 sub, 010 funct field, 011 and, 100 or.
- `pc_source`  out  2  00 ALU, 01 ALUOut, 10 jump target.
- `illegal`  out  1  one-cycle pulse on unknown opcode.
- `mem_err`  out  1  sticky timeout flag.
- `state`  out  4  current state encoding (debug).

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, ALU_WB 7, BRANCH 8, IMM_EXEC 9, JAL 10, ERROR 11.
- FETCH: `mem_read`=1, `i_or_d`=0, src_a 0, src_b 01, op add, pc_source 00; hold until `mem_ready`; in that cycle `ir_write`=`pc_write`=1, next DECODE.
- DECODE: src_a 0, src_b 11, op add (branch target precompute). Next by `op_code`: 0x00→R_EXEC; 0x23/0x2B→MEM_ADDR; 0x04→BRANCH; 0x08/0x0C/0x0D→IMM_EXEC; 0x03→JAL (macro); else `illegal`=1, →FETCH.
- MEM_ADDR: src_a 1, src_b 10, add; →MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `mem_read`=1, `i_or_d`=1; on `mem_ready` →MEM_WB. MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0; →FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1; on `mem_ready` →FETCH.
- R_EXEC: src_a 1, src_b 00, op 010; →ALU_WB (`reg_write`=1, `reg_dst`=1, `mem_to_reg`=0) →FETCH.
- IMM_EXEC: src_a 1, src_b 10, op add/and/or for 0x08/0x0C/0x0D; →ALU_WB with `reg_dst`=0.
- BRANCH: src_a 1, src_b 00, op sub, pc_source 01, `pc_write`=`zero`; →FETCH.
- Outputs not listed for a state are 0. `op_code` latched at DECODE for later states.
- Wait counter: increments each cycle in FETCH/MEM_RD/MEM_WR with `mem_ready`=0, clears on `mem_ready` or state change. Counter reaching `WAIT_MAX` while `mem_ready`=0 → ERROR. ERROR: all strobes 0, `mem_err`=1, held until `reset`.

## Timing
- Zero-wait latency: beq 3 cycles, R-type/imm/sw 4, lw 5, jal 3.
- Each wait cycle adds exactly one cycle; strobes stay asserted and stable throughout.
- Outputs are functions of registered state (plus `mem_ready`/`zero` for `ir_write`, `pc_write`); no output depends on `op_code` combinationally outside DECODE transition.
- During `reset`=1 all outputs 0, `state`=0; first cycle after release is FETCH with `mem_read`=1.
- Reset mid-access aborts immediately; no `reg_write`/`pc_write` follows.
- `mem_ready` high outside memory states is ignored.

## Configuration
- `MCU_JAL_EN` defined: 0x03 → JAL state: `pc_write`=1, pc_source 10, `reg_write`=1, `jal_link`=1; →FETCH.
- Undefined: 0x03 is illegal (`illegal` pulse, →FETCH), JAL state unreachable, `jal_link` tied 0.

## Test plan
- R-type op 0x00, `mem_ready` always 1 → states 0,1,6,7,0; `reg_write`=1 only in state 7 with `reg_dst`=1.
- lw 0x23, FETCH `mem_ready` delayed 3 cycles → `mem_read` held 4 cycles, `ir_write` single pulse, then 1,2,3,4; `mem_to_reg`=1 in 4.
- beq 0x04 with `zero`=1 then `zero`=0 → `pc_write`=1 with pc_source 01 first, `pc_write`=0 second.
- op 0x3F → `illegal` one-cycle pulse in DECODE, next state FETCH, no writes.
- sw with `mem_ready` stuck 0, `WAIT_MAX`=15 → ERROR after 15 wait cycles, `mem_err`=1 until `reset`.
- op 0x03 with and without `MCU_JAL_EN` → state 10 with `jal_link`=1, pc_source 10 / `illegal` pulse.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every mux select and enable of the shared-ALU, single-memory datapath.
// Memory accesses use a ready handshake guarded by a wait timeout.
// Optional feature macro: MCU_JAL_EN (adds the jal link/jump state for 0x03).
//
// state    | code | meaning
// ---------+------+-----------------------------------------------------------
// FETCH    |  0   | read instruction at PC, PC+4 on ALU, load IR/PC on ready
// DECODE   |  1   | precompute branch target, dispatch on opcode
// MEM_ADDR |  2   | rs + sign-ext imm -> ALUOut (effective address)
// MEM_RD   |  3   | load read at ALUOut, wait for ready
// MEM_WB   |  4   | write MDR to rt
// MEM_WR   |  5   | store write at ALUOut, wait for ready
// R_EXEC   |  6   | rs op rt using the funct field
// ALU_WB   |  7   | write ALUOut to rd (R-type) or rt (immediate)
// BRANCH   |  8   | compare rs/rt, load PC from ALUOut when equal
// IMM_EXEC |  9   | rs op sign-ext imm (addi/andi/ori)
// JAL      | 10   | jump to target, link PC into r31
// ERROR    | 11   | memory timeout, all strobes off until reset

module mips_multicycle_ctrl #(
  parameter int ALUOP_W  = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op_code,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               jal_link,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal,
  output logic               mem_err,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EXEC = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4);

  // Counter must hold WAIT_MAX itself: WAIT_MAX not-ready cycles are tolerated,
  // the next not-ready cycle (counter already at WAIT_MAX) is the timeout.
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);
  localparam bit TIMEOUT_EN = (WAIT_MAX != 0);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             in_mem_state;
  logic             timeout;

  assign state = state_q;

  // State, latched opcode and wait counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  // Wait counter: counts consecutive not-ready cycles in a memory state
  always_comb begin
    in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    timeout      = 1'b0;
    wait_d       = '0;
    if (TIMEOUT_EN && in_mem_state && !mem_ready) begin
      if (wait_q == WAIT_LIM) begin
        timeout = 1'b1;
      end else begin
        wait_d = wait_q + CNT_W'(1);
      end
    end
  end

  // Next-state and Moore outputs; everything forced low while reset is held
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    jal_link   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        op_d      = op_code;
        case (op_code)
          OP_RTYPE:             state_d = S_R_EXEC;
          OP_LW, OP_SW:         state_d = S_MEM_ADDR;
          OP_BEQ:               state_d = S_BRANCH;
          OP_ADDI, OP_ANDI,
          OP_ORI:               state_d = S_IMM_EXEC;
`ifdef MCU_JAL_EN
          OP_JAL:               state_d = S_JAL;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)    state_d = S_MEM_WB;
        else if (timeout) state_d = S_ERROR;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_ERROR;
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FN;
        state_d   = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OP_RTYPE);
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = zero;
        state_d   = S_FETCH;
      end

      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_q)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
        state_d = S_ALU_WB;
      end

      S_JAL: begin
`ifdef MCU_JAL_EN
        pc_write  = 1'b1;
        pc_source = 2'b10;
        reg_write = 1'b1;
        jal_link  = 1'b1;
`endif
        state_d = S_FETCH;
      end

      S_ERROR: begin
        mem_err = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      jal_link   = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = ALU_ADD;
      pc_source  = 2'b00;
      illegal    = 1'b0;
      mem_err    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// An instruction-level model expands each opcode into its expected sequence of
// states (with wait cycles) and the output word expected in each cycle.
module tb_mips_multicycle_ctrl;

  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_code;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, jal_link, alu_src_a, illegal, mem_err;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  mips_multicycle_ctrl #(.ALUOP_W(3), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .jal_link(jal_link), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal(illegal), .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  step_t plan[$];

  logic [18:0] obs_vec;
  assign obs_vec = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                    reg_dst, reg_write, jal_link, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal, mem_err};

  function automatic bit jal_on();
`ifdef MCU_JAL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit known_op(input logic [5:0] op);
    case (op)
      6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D: return 1'b1;
      6'h03: return jal_on();
      default: return 1'b0;
    endcase
  endfunction

  // Expected output word for one cycle in a given state
  function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic rdy,
                                          input logic z, input logic [5:0] op);
    logic pcw, irw, iord, mrd, mwr, m2r, rdst, rw, jl, sa, illg, merr;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pcw, irw, iord, mrd, mwr, m2r, rdst, rw, jl, sa, illg, merr} = '0;
    sb = 2'b00; ps = 2'b00; ao = 3'd0;
    case (st)
      4'd0:  begin mrd = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
      4'd1:  begin sb = 2'b11; illg = !known_op(op); end
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin sa = 1; ao = 3'd2; end
      4'd7:  begin rw = 1; rdst = (op == 6'h00); end
      4'd8:  begin sa = 1; ao = 3'd1; ps = 2'b01; pcw = z; end
      4'd9:  begin sa = 1; sb = 2'b10; ao = (op == 6'h0C) ? 3'd3 : (op == 6'h0D) ? 3'd4 : 3'd0; end
      4'd10: begin pcw = 1; ps = 2'b10; rw = 1; jl = 1; end
      4'd11: merr = 1;
      default: ;
    endcase
    return {pcw, irw, iord, mrd, mwr, m2r, rdst, rw, jl, sa, sb, ao, ps, illg, merr};
  endfunction

  task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic rdy);
    step_t s;
    s.st = st;
    s.rdy = rdy;
    plan.push_back(s);
  endtask

  // Expand an instruction into its cycle-by-cycle state trace
  task automatic build_plan(input logic [5:0] op, input int fw, input int mw);
    plan.delete();
    repeat (fw) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'($urandom_range(0, 1)));
    if (!known_op(op)) return;
    case (op)
      6'h00: begin push(4'd6, 1'($urandom_range(0, 1))); push(4'd7, 1'($urandom_range(0, 1))); end
      6'h08, 6'h0C, 6'h0D: begin
        push(4'd9, 1'($urandom_range(0, 1))); push(4'd7, 1'($urandom_range(0, 1)));
      end
      6'h23: begin
        push(4'd2, 1'($urandom_range(0, 1)));
        repeat (mw) push(4'd3, 1'b0);
        push(4'd3, 1'b1);
        push(4'd4, 1'($urandom_range(0, 1)));
      end
      6'h2B: begin
        push(4'd2, 1'($urandom_range(0, 1)));
        repeat (mw) push(4'd5, 1'b0);
        push(4'd5, 1'b1);
      end
      6'h04: push(4'd8, 1'($urandom_range(0, 1)));
      6'h03: push(4'd10, 1'($urandom_range(0, 1)));
      default: ;
    endcase
  endtask

  // Drive the first n plan cycles (n<0: all) and check state and outputs each cycle
  task automatic run_plan(input logic [5:0] op, input logic z, input int n, input string tag);
    int lim;
    lim = (n < 0 || n > plan.size()) ? plan.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      op_code   = op;
      zero      = z;
      mem_ready = plan[i].rdy;
      #1;
      chk($sformatf("%s state c%0d", tag, i), {15'd0, state}, {15'd0, plan[i].st});
      chk($sformatf("%s outs c%0d", tag, i), obs_vec, exp_vec(plan[i].st, plan[i].rdy, z, op));
    end
  endtask

  task automatic do_instr(input logic [5:0] op, input int fw, input int mw,
                          input logic z, input string tag);
    build_plan(op, fw, mw);
    run_plan(op, z, -1, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    #1;
    chk("reset state", {15'd0, state}, 19'd0);
    chk("reset outs", obs_vec, 19'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset held outs", obs_vec, 19'd0);
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("post reset state", {15'd0, state}, 19'd0);
    chk("post reset outs", obs_vec, exp_vec(4'd0, 1'b0, zero, op_code));
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    int k;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h03};
    reset = 1'b1; op_code = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    do_instr(6'h00, 0, 0, 1'b0, "rtype");
    do_instr(6'h23, 3, 0, 1'b0, "lw fetch wait3");
    do_instr(6'h04, 0, 0, 1'b1, "beq taken");
    do_instr(6'h04, 0, 0, 1'b0, "beq not taken");
    do_instr(6'h3F, 0, 0, 1'b0, "illegal 3f");
    do_instr(6'h03, 0, 0, 1'b0, "jal");
    do_instr(6'h2B, 1, 2, 1'b0, "sw wait2");
    do_instr(6'h08, 0, 0, 1'b1, "addi");
    do_instr(6'h0C, 0, 0, 1'b0, "andi");
    do_instr(6'h0D, 2, 0, 1'b0, "ori");
    do_instr(6'h23, 0, WAIT_MAX, 1'b0, "lw max wait");

    // Reset in the middle of a load's wait: no writeback may follow
    build_plan(6'h23, 0, 5);
    run_plan(6'h23, 1'b0, 6, "lw aborted");
    do_reset();
    do_instr(6'h00, 0, 0, 1'b0, "rtype after abort");

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 8);
      if (k < 8) op = ops[k];
      else begin
        op = 6'($urandom_range(0, 63));
        while (known_op(op) || op == 6'h03) op = 6'($urandom_range(0, 63));
      end
      do_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
               $sformatf("rand%0d op%h", n, op));
    end

    // Store with memory never ready: WAIT_MAX tolerated, next miss enters ERROR
    plan.delete();
    push(4'd0, 1'b1);
    push(4'd1, 1'b0);
    push(4'd2, 1'b0);
    repeat (WAIT_MAX + 1) push(4'd5, 1'b0);
    repeat (4) push(4'd11, 1'($urandom_range(0, 1)));
    run_plan(6'h2B, 1'b0, -1, "sw timeout");
    do_reset();
    do_instr(6'h00, 0, 0, 1'b0, "rtype after error");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
